// File: rtl/mcpu_pkg.sv
// Shared MCPU definitions: command encodings, sequencer state type and
// default datapath widths.
package mcpu_pkg;

  localparam int DEF_WORD_SIZE         = 8;
  localparam int DEF_ADDR_WIDTH        = 8;
  localparam int DEF_REGS_NUMBER_WIDTH = 4;

  localparam logic [2:0] CMD_ALU_WB    = 3'b000;
  localparam logic [2:0] CMD_MOV       = 3'b001;
  localparam logic [2:0] CMD_LOAD_IMM  = 3'b010;
  localparam logic [2:0] CMD_LOAD_MEM  = 3'b011;
  localparam logic [2:0] CMD_STORE_MEM = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_LOAD  = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/mcpu_regfile_array.sv
// 3-read / 1-write register storage with asynchronous clear.
// Build option MCPU_REGFILE_ZERO_REG_EN: register 0 is hardwired to zero
// (writes dropped, reads return 0). Reads never bypass a same-cycle write.
module mcpu_regfile_array
  import mcpu_pkg::*;
#(
  parameter int WORD_SIZE         = DEF_WORD_SIZE,
  parameter int REGS_NUMBER_WIDTH = DEF_REGS_NUMBER_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [REGS_NUMBER_WIDTH-1:0] waddr,
  input  logic [WORD_SIZE-1:0]         wdata,
  input  logic [REGS_NUMBER_WIDTH-1:0] raddr1,
  input  logic [REGS_NUMBER_WIDTH-1:0] raddr2,
  input  logic [REGS_NUMBER_WIDTH-1:0] raddr3,
  output logic [WORD_SIZE-1:0]         rdata1,
  output logic [WORD_SIZE-1:0]         rdata2,
  output logic [WORD_SIZE-1:0]         rdata3
);

  localparam int REGISTERS_NUMBER = 1 << REGS_NUMBER_WIDTH;

  logic [WORD_SIZE-1:0] regs [REGISTERS_NUMBER];
  logic                 we_eff;

`ifdef MCPU_REGFILE_ZERO_REG_EN
  assign we_eff = we && (waddr != '0);
  assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
  assign rdata3 = (raddr3 == '0) ? '0 : regs[raddr3];
`else
  assign we_eff = we;
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
  assign rdata3 = regs[raddr3];
`endif

  // Storage: cleared on reset, single write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGISTERS_NUMBER; i++) regs[i] <= '0;
    end else if (we_eff) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/mcpu_regfile_lsu.sv
// MCPU register file with command-driven load/store sequencer.
// Build option MCPU_REGFILE_ZERO_REG_EN (see mcpu_regfile_array).
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | accepting commands; register-only commands complete here
//  ST_STORE | single mem_we cycle for a STORE_MEM
//  ST_LOAD  | mem_re held while the read-latency counter runs down to 0
module mcpu_regfile_lsu
  import mcpu_pkg::*;
#(
  parameter int WORD_SIZE         = DEF_WORD_SIZE,
  parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
  parameter int REGS_NUMBER_WIDTH = DEF_REGS_NUMBER_WIDTH,
  parameter int MEM_RD_LATENCY    = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [2:0]                   cmd,
  input  logic [REGS_NUMBER_WIDTH-1:0] op1,
  input  logic [REGS_NUMBER_WIDTH-1:0] op2,
  input  logic [REGS_NUMBER_WIDTH-1:0] op3,
  input  logic [WORD_SIZE-1:0]         datatoload,
  input  logic [WORD_SIZE-1:0]         alu_result,
  input  logic [ADDR_WIDTH-1:0]        memaddr,
  output logic [WORD_SIZE-1:0]         RegOp1,
  output logic [WORD_SIZE-1:0]         alu1,
  output logic [WORD_SIZE-1:0]         alu2,
  output logic                         mem_we,
  output logic                         mem_re,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [WORD_SIZE-1:0]         mem_datawr,
  input  logic [WORD_SIZE-1:0]         mem_datard,
  output logic                         cmd_done,
  output logic                         cmd_err
);

  localparam logic [2:0] RD_LAT = 3'(MEM_RD_LATENCY);

  lsu_state_t                   state, state_nxt;
  logic [2:0]                   cnt;
  logic [REGS_NUMBER_WIDTH-1:0] dest;
  logic                         rf_we;
  logic [REGS_NUMBER_WIDTH-1:0] rf_waddr;
  logic [WORD_SIZE-1:0]         rf_wdata;
  logic                         done_nxt, err_nxt;

  mcpu_regfile_array #(
    .WORD_SIZE        (WORD_SIZE),
    .REGS_NUMBER_WIDTH(REGS_NUMBER_WIDTH)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .raddr1(op1),
    .raddr2(op2),
    .raddr3(op3),
    .rdata1(RegOp1),
    .rdata2(alu1),
    .rdata3(alu2)
  );

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state, strobes, register write port and completion flags.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = op1;
    rf_wdata  = alu_result;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd)
            CMD_ALU_WB:    begin rf_we = 1'b1; rf_wdata = alu_result; done_nxt = 1'b1; end
            CMD_MOV:       begin rf_we = 1'b1; rf_wdata = alu1;       done_nxt = 1'b1; end
            CMD_LOAD_IMM:  begin rf_we = 1'b1; rf_wdata = datatoload; done_nxt = 1'b1; end
            CMD_STORE_MEM: begin state_nxt = ST_STORE; done_nxt = 1'b1; end
            CMD_LOAD_MEM:  state_nxt = ST_LOAD;
            default:       err_nxt = 1'b1;
          endcase
        end
      end
      ST_STORE: begin
        mem_we    = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_LOAD: begin
        mem_re = 1'b1;
        if (cnt == 3'd0) begin
          rf_we     = 1'b1;
          rf_waddr  = dest;
          rf_wdata  = mem_datard;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Memory-side capture at accept, read-latency down-counter, status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr   <= '0;
      mem_datawr <= '0;
      dest       <= '0;
      cnt        <= '0;
      cmd_done   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      cmd_done <= done_nxt;
      cmd_err  <= err_nxt;
      if (cmd_valid && cmd_ready && cmd == CMD_STORE_MEM) begin
        mem_addr   <= memaddr;
        mem_datawr <= RegOp1;
      end else if (cmd_valid && cmd_ready && cmd == CMD_LOAD_MEM) begin
        mem_addr <= memaddr;
        dest     <= op1;
        cnt      <= RD_LAT;
      end else if (state == ST_LOAD && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_mcpu_regfile_lsu.sv
// Bench for mcpu_regfile_lsu: two instances (read latency 0 and 3) exercised
// in turn by directed and random commands against a behavioural model.
module tb_mcpu_regfile_lsu;
  import mcpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       cmd_valid [2];
  logic [2:0] cmd;
  logic [3:0] op1, op2, op3;
  logic [7:0] datatoload, alu_result, memaddr;

  logic       dut_ready [2];
  logic       dut_we    [2];
  logic       dut_re    [2];
  logic       dut_done  [2];
  logic       dut_err   [2];
  logic [7:0] dut_regop1 [2];
  logic [7:0] dut_alu1  [2];
  logic [7:0] dut_alu2  [2];
  logic [7:0] dut_addr  [2];
  logic [7:0] dut_wdata [2];
  logic [7:0] dut_rdata [2];

  int   sel = 0;
  bit   alu_xor = 1'b0;
  int   n_pass = 0, n_fail = 0, n_total = 0;

  logic [7:0] ref_r [16];
  logic [7:0] exp_mem [int];

  // ALU stand-in: ADD or XOR of the selected instance's operand reads
  assign alu_result = alu_xor ? (dut_alu1[sel] ^ dut_alu2[sel]) : (dut_alu1[sel] + dut_alu2[sel]);

  mcpu_regfile_lsu #(.MEM_RD_LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[0]), .cmd_ready(dut_ready[0]),
    .cmd(cmd), .op1(op1), .op2(op2), .op3(op3), .datatoload(datatoload),
    .alu_result(alu_result), .memaddr(memaddr), .RegOp1(dut_regop1[0]),
    .alu1(dut_alu1[0]), .alu2(dut_alu2[0]), .mem_we(dut_we[0]), .mem_re(dut_re[0]),
    .mem_addr(dut_addr[0]), .mem_datawr(dut_wdata[0]), .mem_datard(dut_rdata[0]),
    .cmd_done(dut_done[0]), .cmd_err(dut_err[0]));

  mcpu_regfile_lsu #(.MEM_RD_LATENCY(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid[1]), .cmd_ready(dut_ready[1]),
    .cmd(cmd), .op1(op1), .op2(op2), .op3(op3), .datatoload(datatoload),
    .alu_result(alu_result), .memaddr(memaddr), .RegOp1(dut_regop1[1]),
    .alu1(dut_alu1[1]), .alu2(dut_alu2[1]), .mem_we(dut_we[1]), .mem_re(dut_re[1]),
    .mem_addr(dut_addr[1]), .mem_datawr(dut_wdata[1]), .mem_datard(dut_rdata[1]),
    .cmd_done(dut_done[1]), .cmd_err(dut_err[1]));

  // RAM model: unwritten locations hold a pattern; data is only correct in the
  // mem_re cycle matching the instance latency, complemented before that.
  logic [7:0] ram   [2][256];
  bit         ram_v [2][256];
  int         re_cnt [2];
  logic [7:0] ram_word [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (dut_we[k]) begin
        ram[k][dut_addr[k]]   <= dut_wdata[k];
        ram_v[k][dut_addr[k]] <= 1'b1;
      end
      re_cnt[k] <= dut_re[k] ? re_cnt[k] + 1 : 0;
    end
  end

  assign ram_word[0] = ram_v[0][dut_addr[0]] ? ram[0][dut_addr[0]] : 8'(32'(dut_addr[0]) * 7 + 3);
  assign ram_word[1] = ram_v[1][dut_addr[1]] ? ram[1][dut_addr[1]] : 8'(32'(dut_addr[1]) * 7 + 3);
  assign dut_rdata[0] = (dut_re[0] && re_cnt[0] == 0) ? ram_word[0] : ~ram_word[0];
  assign dut_rdata[1] = (dut_re[1] && re_cnt[1] == 3) ? ram_word[1] : ~ram_word[1];

  function automatic logic [7:0] m_mem(int k, logic [7:0] a);
    int key = k * 256 + int'(a);
    if (exp_mem.exists(key)) return exp_mem[key];
    return 8'(int'(a) * 7 + 3);
  endfunction

  function automatic void m_write(logic [3:0] idx, logic [7:0] v);
`ifdef MCPU_REGFILE_ZERO_REG_EN
    if (idx == 4'd0) return;
`endif
    ref_r[idx] = v;
  endfunction

  task automatic chk8(string tag, logic [7:0] obs, logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s[k%0d]: observed 0x%0h expected 0x%0h", tag, sel, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s[k%0d]: observed %b expected %b", tag, sel, obs, exp);
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < 16; i++) begin
      op1 = 4'(i); op2 = 4'(i); op3 = 4'((i + 1) % 16);
      @(negedge clk);
      chk8("regop1", dut_regop1[sel], ref_r[i]);
      chk8("alu1", dut_alu1[sel], ref_r[i]);
      chk8("alu2", dut_alu2[sel], ref_r[(i + 1) % 16]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk1("rst_ready", dut_ready[sel], 1'b1);
    chk1("rst_we", dut_we[sel], 1'b0);
    chk1("rst_re", dut_re[sel], 1'b0);
    chk1("rst_done", dut_done[sel], 1'b0);
    chk1("rst_err", dut_err[sel], 1'b0);
    chk8("rst_addr", dut_addr[sel], 8'h00);
    chk8("rst_wdata", dut_wdata[sel], 8'h00);
    for (int i = 0; i < 16; i++) ref_r[i] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one command at a negedge and follow it to completion.
  task automatic issue(logic [2:0] c, logic [3:0] d, logic [3:0] s2, logic [3:0] s3,
                       logic [7:0] imm, logic [7:0] a, bit xr);
    int lat = (sel == 0) ? 0 : 3;
    logic [7:0] expv;
    cmd = c; op1 = d; op2 = s2; op3 = s3; datatoload = imm; memaddr = a; alu_xor = xr;
    cmd_valid[sel] = 1'b1;
    #1;
    chk1("ready_at_issue", dut_ready[sel], 1'b1);
    expv = 8'h00;
    case (c)
      CMD_ALU_WB:    expv = xr ? (ref_r[s2] ^ ref_r[s3]) : (ref_r[s2] + ref_r[s3]);
      CMD_MOV:       expv = ref_r[s2];
      CMD_LOAD_IMM:  expv = imm;
      CMD_STORE_MEM: expv = ref_r[d];
      default:       expv = 8'h00;
    endcase
    @(posedge clk);
    #1;
    cmd_valid[sel] = 1'b0;
    @(negedge clk);
    case (c)
      CMD_ALU_WB, CMD_MOV, CMD_LOAD_IMM: begin
        m_write(d, expv);
        chk1("reg_done", dut_done[sel], 1'b1);
        chk1("reg_err", dut_err[sel], 1'b0);
        chk1("reg_ready", dut_ready[sel], 1'b1);
      end
      CMD_STORE_MEM: begin
        chk1("st_we", dut_we[sel], 1'b1);
        chk1("st_re", dut_re[sel], 1'b0);
        chk8("st_addr", dut_addr[sel], a);
        chk8("st_data", dut_wdata[sel], expv);
        chk1("st_done", dut_done[sel], 1'b1);
        chk1("st_ready", dut_ready[sel], 1'b0);
        exp_mem[sel * 256 + int'(a)] = expv;
        @(negedge clk);
        chk1("st_we_end", dut_we[sel], 1'b0);
        chk1("st_ready_end", dut_ready[sel], 1'b1);
        chk1("st_done_end", dut_done[sel], 1'b0);
      end
      CMD_LOAD_MEM: begin
        for (int i = 0; i <= lat; i++) begin
          chk1("ld_re", dut_re[sel], 1'b1);
          chk1("ld_we", dut_we[sel], 1'b0);
          chk1("ld_ready", dut_ready[sel], 1'b0);
          chk1("ld_done", dut_done[sel], 1'b0);
          chk8("ld_addr", dut_addr[sel], a);
          @(negedge clk);
        end
        chk1("ld_re_end", dut_re[sel], 1'b0);
        chk1("ld_done_end", dut_done[sel], 1'b1);
        chk1("ld_ready_end", dut_ready[sel], 1'b1);
        m_write(d, m_mem(sel, a));
        op1 = d;
        #1;
        chk8("ld_value", dut_regop1[sel], ref_r[d]);
      end
      default: begin
        chk1("ill_err", dut_err[sel], 1'b1);
        chk1("ill_done", dut_done[sel], 1'b0);
        chk1("ill_ready", dut_ready[sel], 1'b1);
      end
    endcase
  endtask

  initial begin
    cmd_valid[0] = 1'b0; cmd_valid[1] = 1'b0;
    cmd = 3'b000; op1 = '0; op2 = '0; op3 = '0;
    datatoload = '0; memaddr = '0;
    for (int k = 0; k < 2; k++) begin
      sel = k;
      @(negedge clk);
      do_reset();
      check_regs();

      issue(CMD_LOAD_IMM, 4'd0, 4'd0, 4'd0, 8'd46, 8'd0, 1'b0);
      issue(CMD_LOAD_IMM, 4'd1, 4'd0, 4'd0, 8'd54, 8'd0, 1'b0);
      issue(CMD_STORE_MEM, 4'd0, 4'd0, 4'd0, 8'd0, 8'd100, 1'b0);
      issue(CMD_STORE_MEM, 4'd1, 4'd0, 4'd0, 8'd0, 8'd101, 1'b0);
      issue(CMD_LOAD_MEM, 4'd2, 4'd0, 4'd0, 8'd0, 8'd100, 1'b0);
      issue(CMD_LOAD_MEM, 4'd3, 4'd0, 4'd0, 8'd0, 8'd101, 1'b0);
      issue(CMD_ALU_WB, 4'd4, 4'd2, 4'd3, 8'd0, 8'd0, 1'b0);
      issue(CMD_ALU_WB, 4'd5, 4'd2, 4'd3, 8'd0, 8'd0, 1'b1);
      issue(CMD_MOV, 4'd6, 4'd4, 4'd0, 8'd0, 8'd0, 1'b0);
      issue(CMD_LOAD_IMM, 4'd4, 4'd0, 4'd0, 8'd7, 8'd0, 1'b0);
      issue(3'b111, 4'd4, 4'd1, 4'd2, 8'd99, 8'd100, 1'b0);
      issue(3'b101, 4'd5, 4'd1, 4'd2, 8'd98, 8'd101, 1'b0);
      check_regs();

      for (int n = 0; n < 40; n++) begin
        issue(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom),
              8'($urandom), 8'($urandom_range(96, 104)), 1'($urandom));
      end
      check_regs();

      // reset in the middle of a load
      cmd = CMD_LOAD_MEM; op1 = 4'd7; memaddr = 8'd100; cmd_valid[sel] = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid[sel] = 1'b0;
      @(negedge clk);
      chk1("midld_re", dut_re[sel], 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("midld_re_drop", dut_re[sel], 1'b0);
      chk1("midld_ready", dut_ready[sel], 1'b1);
      for (int i = 0; i < 16; i++) ref_r[i] = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      check_regs();

      issue(CMD_LOAD_IMM, 4'd0, 4'd0, 4'd0, 8'd9, 8'd0, 1'b0);
      op1 = 4'd0;
      #1;
      chk8("r0_after_imm", dut_regop1[sel], ref_r[0]);
      @(negedge clk);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
